// File: rtl/fp_add_issue_if.sv
// Upstream operand-pair handshake into the adder issue queue.
interface fp_add_issue_if #(
  parameter int TAG_W = 4
);
  logic             s_vld;
  logic             s_rdy;
  logic [31:0]      s_a;
  logic [31:0]      s_b;
  logic             s_sub;
  logic [TAG_W-1:0] s_tag;

  modport master (output s_vld, s_a, s_b, s_sub, s_tag, input s_rdy);
  modport slave  (input s_vld, s_a, s_b, s_sub, s_tag, output s_rdy);
endinterface

// File: rtl/fp_add_issue.sv
// Operand issue queue feeding the FP32 adder: FIFO buffering, subtract sign flip,
// and a tag pipe aligned with the adder's registered result.
module fp_add_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  fp_add_issue_if.slave              up,
  input  logic                       flush,
  input  logic                       stall,
  output logic [31:0]                add_a,
  output logic [31:0]                add_b,
  output logic                       add_vld,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       res_tag_vld,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Sign flip is unconditional; special operands are left to the adder.
  function automatic logic [31:0] sub_flip(input logic [31:0] b, input logic sub);
    return sub ? {~b[31], b[30:0]} : b;
  endfunction

  logic [31:0]      mem_a_q   [DEPTH];
  logic [31:0]      mem_b_q   [DEPTH];
  logic             mem_sub_q [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  logic [31:0]      add_a_p1_q, add_b_p1_q;
  logic             vld_p1_q;
  logic [TAG_W-1:0] tag_p1_q;
  logic [TAG_W-1:0] res_tag_p2_q;
  logic             vld_p2_q;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign up.s_rdy = !rst && !flush && !full;
  assign push     = up.s_vld && up.s_rdy;
  assign pop      = !empty && !stall && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage (p0): entry payload, not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]   <= up.s_a;
      mem_b_q[wr_ptr_q]   <= up.s_b;
      mem_sub_q[wr_ptr_q] <= up.s_sub;
      mem_tag_q[wr_ptr_q] <= up.s_tag;
    end
  end

  // Issue stage (p1): adder operand registers, zeroed when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a_p1_q <= '0;
      add_b_p1_q <= '0;
      vld_p1_q   <= 1'b0;
      tag_p1_q   <= '0;
    end else begin
      vld_p1_q   <= pop;
      add_a_p1_q <= pop ? mem_a_q[rd_ptr_q] : '0;
      add_b_p1_q <= pop ? sub_flip(mem_b_q[rd_ptr_q], mem_sub_q[rd_ptr_q]) : '0;
      tag_p1_q   <= pop ? mem_tag_q[rd_ptr_q] : '0;
    end
  end

  // Result stage (p2): tag lines up with adder o_res_vld
  always_ff @(posedge clk) begin
    if (rst) begin
      res_tag_p2_q <= '0;
      vld_p2_q     <= 1'b0;
    end else begin
      res_tag_p2_q <= tag_p1_q;
      vld_p2_q     <= vld_p1_q;
    end
  end

  assign add_a       = add_a_p1_q;
  assign add_b       = add_b_p1_q;
  assign add_vld     = vld_p1_q;
  assign res_tag     = res_tag_p2_q;
  assign res_tag_vld = vld_p2_q;
  assign count       = count_q;
endmodule

// File: tb/tb_fp_add_issue.sv
// Directed bench for fp_add_issue: handshake, sign flip, fill/wrap, flush and reset.
module tb_fp_add_issue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst, flush, stall;
  logic [31:0] add_a, add_b;
  logic add_vld, res_tag_vld, empty, full;
  logic [TAG_W-1:0] res_tag;
  logic [$clog2(DEPTH):0] count;

  int n_vec = 0;
  int n_err = 0;

  fp_add_issue_if #(.TAG_W(TAG_W)) up ();

  fp_add_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .up(up), .flush(flush), .stall(stall),
    .add_a(add_a), .add_b(add_b), .add_vld(add_vld),
    .res_tag(res_tag), .res_tag_vld(res_tag_vld),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [TAG_W-1:0] tag);
    up.s_vld = v; up.s_a = a; up.s_b = b; up.s_sub = sub; up.s_tag = tag;
  endtask

  logic [31:0] fa [4];
  logic [31:0] fb [4];
  logic        fs [4];
  logic [31:0] fexp [4];

  initial begin
    fa = '{32'h40000000, 32'h40000001, 32'h40000002, 32'h40000003};
    fb = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000};
    fs = '{1'b1, 1'b1, 1'b1, 1'b0};
    fexp = '{32'h80000000, 32'h00000000, 32'hFF800000, 32'h7FC00000};

    rst = 1'b1; flush = 1'b0; stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
    tick(); tick();
    chk("rst_add_vld", add_vld, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_res_vld", res_tag_vld, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_s_rdy", up.s_rdy, 0);
    rst = 1'b0; #1;
    chk("post_rst_s_rdy", up.s_rdy, 1);

    // single add, tag 3
    drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 4'd3);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
    chk("add_count_T", count, 1);
    chk("add_vld_T", add_vld, 0);
    tick();
    chk("add_vld_T1", add_vld, 1);
    chk("add_a_T1", add_a, 32'h3F800000);
    chk("add_b_T1", add_b, 32'h40000000);
    chk("add_resvld_T1", res_tag_vld, 0);
    chk("add_count_T1", count, 0);
    tick();
    chk("add_resvld_T2", res_tag_vld, 1);
    chk("add_restag_T2", res_tag, 3);
    chk("add_vld_T2", add_vld, 0);
    chk("add_a_idle", add_a, 0);
    tick();
    chk("add_resvld_T3", res_tag_vld, 0);

    // subtract, tag 5
    drive(1'b1, 32'h40400000, 32'h3F800000, 1'b1, 4'd5);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
    tick();
    chk("sub_add_a", add_a, 32'h40400000);
    chk("sub_add_b", add_b, 32'hBF800000);
    tick();
    chk("sub_restag", res_tag, 5);
    chk("sub_resvld", res_tag_vld, 1);

    // fill under stall, then drain in order
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fa[i], fb[i], fs[i], TAG_W'(i));
      tick();
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    drive(1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 4'd9);
    #1;
    chk("fill_s_rdy", up.s_rdy, 0);
    tick();
    chk("fill_count_hold", count, 4);
    chk("fill_no_issue", add_vld, 0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_vld", add_vld, 1);
      chk("drain_a", add_a, fa[i]);
      chk("drain_b", add_b, fexp[i]);
      if (i > 0) begin
        chk("drain_resvld", res_tag_vld, 1);
        chk("drain_restag", res_tag, i - 1);
      end
    end
    tick();
    chk("drain_end_vld", add_vld, 0);
    chk("drain_last_tag", res_tag, 3);
    chk("drain_empty", empty, 1);

    // wrap: DEPTH+2 back-to-back pushes, tags 10..15
    for (int j = 0; j < 8; j++) begin
      if (j < 6) drive(1'b1, 32'h50000000 + j, 32'h1, 1'b0, TAG_W'(10 + j));
      else       drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
      tick();
      chk("wrap_vld", add_vld, (j >= 1 && j <= 6) ? 1 : 0);
      if (j >= 1 && j <= 6) chk("wrap_a", add_a, 32'h50000000 + j - 1);
      chk("wrap_resvld", res_tag_vld, (j >= 2) ? 1 : 0);
      if (j >= 2) chk("wrap_restag", res_tag, 10 + j - 2);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
    tick();

    // simultaneous push and pop at count=2
    stall = 1'b1;
    drive(1'b1, 32'h10000001, 32'h0, 1'b0, 4'd1); tick();
    drive(1'b1, 32'h10000002, 32'h0, 1'b0, 4'd2); tick();
    chk("pp_count0", count, 2);
    stall = 1'b0;
    drive(1'b1, 32'h10000003, 32'h0, 1'b0, 4'd3); tick();
    chk("pp_count1", count, 2);
    chk("pp_a1", add_a, 32'h10000001);
    drive(1'b1, 32'h10000004, 32'h0, 1'b0, 4'd4); tick();
    chk("pp_count2", count, 2);
    chk("pp_a2", add_a, 32'h10000002);
    drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
    tick();
    chk("pp_a3", add_a, 32'h10000003);
    tick();
    chk("pp_a4", add_a, 32'h10000004);
    chk("pp_count_end", count, 0);
    tick();
    chk("pp_idle", add_vld, 0);

    // full with concurrent pop: push still refused
    stall = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      drive(1'b1, 32'h10000000 + k, 32'h0, 1'b0, TAG_W'(k));
      tick();
    end
    stall = 1'b0;
    drive(1'b1, 32'h10000009, 32'h0, 1'b0, 4'd9);
    #1;
    chk("fullpop_s_rdy", up.s_rdy, 0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
    chk("fullpop_count", count, 3);
    chk("fullpop_a5", add_a, 32'h10000005);
    for (int k = 6; k <= 8; k++) begin
      tick();
      chk("fullpop_a", add_a, 32'h10000000 + k);
    end
    tick();
    chk("fullpop_no_extra", add_vld, 0);
    chk("fullpop_empty", empty, 1);

    // flush with 3 queued and 1 in flight
    stall = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 32'h20000000 + k, 32'h0, 1'b0, TAG_W'(k));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
    stall = 1'b0;
    tick();
    chk("fl_issue", add_vld, 1);
    chk("fl_count3", count, 3);
    flush = 1'b1; #1;
    chk("fl_s_rdy_low", up.s_rdy, 0);
    tick();
    flush = 1'b0;
    chk("fl_count0", count, 0);
    chk("fl_no_pop", add_vld, 0);
    chk("fl_inflight_vld", res_tag_vld, 1);
    chk("fl_inflight_tag", res_tag, 1);
    #1;
    chk("fl_s_rdy_back", up.s_rdy, 1);
    tick();
    chk("fl_after_vld", add_vld, 0);
    chk("fl_after_res", res_tag_vld, 0);

    // reset mid-burst
    stall = 1'b1;
    drive(1'b1, 32'h30000001, 32'h1, 1'b1, 4'd6); tick();
    drive(1'b1, 32'h30000002, 32'h2, 1'b1, 4'd7); tick();
    stall = 1'b0;
    drive(1'b1, 32'h30000003, 32'h3, 1'b1, 4'd8); tick();
    chk("mr_issue", add_vld, 1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, '0);
    rst = 1'b1;
    tick();
    chk("mr_add_vld", add_vld, 0);
    chk("mr_add_a", add_a, 0);
    chk("mr_add_b", add_b, 0);
    chk("mr_res_vld", res_tag_vld, 0);
    chk("mr_res_tag", res_tag, 0);
    chk("mr_count", count, 0);
    chk("mr_s_rdy", up.s_rdy, 0);
    rst = 1'b0; #1;
    chk("mr_s_rdy_after", up.s_rdy, 1);
    tick();
    chk("mr_stale_vld", add_vld, 0);
    chk("mr_stale_res", res_tag_vld, 0);
    tick();
    chk("mr_stale_res2", res_tag_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fp_add_issue.md
# fp_add_issue

Operand issue queue directly upstream of the 32-bit floating-point adder. It accepts operand pairs with an optional subtract flag over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It issues one pair per cycle to the adder's `i_a`/`i_b`/`i_vld` inputs, applying the subtract sign flip. It delays each pair's tag so the tag lines up with the adder's one-cycle-registered result.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- TAG_W, 4, width of the caller-supplied transaction tag
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; synchronous, active-high
- s_vld  in  1  upstream operand pair valid
- s_rdy  out  1  queue can accept; 0 while rst or flush high, or when full
- s_a  in  32  operand A, IEEE-754 single
- s_b  in  32  operand B, IEEE-754 single
- s_sub  in  1  1 = compute A−B
- s_tag  in  TAG_W  transaction tag
- flush  in  1  discard all queued, not-yet-issued entries
- stall  in  1  hold issue (downstream back-pressure)
- add_a  out  32  registered to adder `i_a`
- add_b  out  32  registered to adder `i_b`
- add_vld  out  1  registered to adder `i_vld`
- res_tag  out  TAG_W  tag aligned with adder `o_res_vld`
- res_tag_vld  out  1  qualifies res_tag
- count  out  $clog2(DEPTH)+1  entries held
- empty, full  out  1  status from count

## Operation
- Push: `s_vld && s_rdy` at an edge writes {s_a, s_b, s_sub, s_tag} at wr_ptr. wr_ptr increments and wraps at DEPTH.
- `s_rdy = !rst && !flush && !full`. It is combinational from registered count. A pop in the same cycle does not free a slot for a push into a full queue.
- Pop/issue: at an edge with `!empty && !stall && !flush`, read the rd_ptr entry into the output registers and increment rd_ptr with wrap:
  - add_a ← a
  - add_b ← sub ? {~b[31], b[30:0]} : b. The flip is unconditional, including NaN, Inf and zero. The adder handles the special cases.
  - add_vld ← 1
  - tag_d ← tag
- At an edge with no pop, add_vld ← 0. add_a/add_b are cleared to 0, matching the adder's zeroing of idle outputs.
- Tag pipe: res_tag ← tag_d and res_tag_vld ← add_vld, one edge after issue.
- count: +1 on push only, −1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Flush: at the edge, pointers and count go to 0. No pop occurs and no push is accepted. The current add_vld/res_tag_vld pipeline contents are not cancelled and drain normally.
- Stall: freezes rd_ptr. add_vld drops to 0 the next edge. Pushes continue while not full.

## Timing
- Reset, at the edge with rst=1: pointers, count, add_a, add_b, add_vld, tag_d, res_tag and res_tag_vld are 0. empty=1, full=0. s_rdy=0 during reset and 1 in the first cycle after.
- Reset mid-operation discards queued entries and in-flight tags. No res_tag_vld is produced for them.
- Latency, with handshake at edge T and queue otherwise empty and unstalled:
  - add_vld high during the cycle after edge T+1
  - adder o_res_vld and res_tag_vld both high during the cycle after edge T+2
- There is no same-cycle bypass from push to issue.
- Throughput: one issue per cycle while non-empty and unstalled.
- Order: strict FIFO, so res_tag order equals acceptance order.

## Test plan
- Single add: push a=0x3F800000, b=0x40000000, sub=0, tag=3 → add_vld after edge T+1 with add_b=0x40000000. res_tag=3 and res_tag_vld coincide with adder o_res=0x40400000.
- Subtract: push a=0x40400000, b=0x3F800000, sub=1 → add_b=0xBF800000. Adder result is 0x40000000.
- Fill/wrap: hold stall=1 and push DEPTH pairs → full=1, s_rdy=0, extra push not accepted. Release stall → DEPTH consecutive add_vld pulses in order. Then push DEPTH+2 more to exercise pointer wrap, with tags checked in order.
- Simultaneous push and pop at count=2 → count stays 2 and data order is preserved. At count=DEPTH, s_rdy=0 even though a pop occurs.
- Flush with 3 queued and 1 issued in flight → the in-flight res_tag_vld still appears, no further add_vld, count=0, s_rdy low only during the flush cycle.
- Reset asserted mid-burst → all outputs 0 at the next edge, no stale res_tag_vld afterward, s_rdy=1 the cycle after rst deasserts.
